// File: rtl/fdma_pkg.sv
// rtl/fdma_pkg.sv - shared widths, state encoding and round-robin pick for the FDMA arbiter
package fdma_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int SIZE_W_DEF = 16;
  localparam int DATA_W_DEF = 128;
  localparam int NCLIENT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

  // One-hot winner; on a tie the client that was not served last wins.
  function automatic logic [NCLIENT-1:0] rr_pick(input logic [NCLIENT-1:0] req,
                                                 input logic               last_gnt);
    if (req == 2'b11) begin
      return last_gnt ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/fdma_arb_ch.sv
// rtl/fdma_arb_ch.sv - one arbitrated FDMA channel: FSM, round-robin pointer, request latch, grant mux
module fdma_arb_ch
  import fdma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NCLIENT-1:0]             c_areq,
  input  logic [NCLIENT-1:0][ADDR_W-1:0] c_addr,
  input  logic [NCLIENT-1:0][SIZE_W-1:0] c_size,
  input  logic [NCLIENT-1:0][DATA_W-1:0] c_data,
  input  logic [NCLIENT-1:0]             c_ready,
  output logic [NCLIENT-1:0]             c_busy,
  output logic [NCLIENT-1:0]             c_valid,
  output logic [ADDR_W-1:0]              fdma_addr,
  output logic [SIZE_W-1:0]              fdma_size,
  output logic                           fdma_areq,
  input  logic                           fdma_busy,
  input  logic                           fdma_valid,
  output logic [DATA_W-1:0]              fdma_data,
  output logic                           fdma_ready,
  output logic [NCLIENT-1:0]             gnt
);

  arb_state_e          state_q, state_d;
  logic [NCLIENT-1:0]  gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                areq_q, areq_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [NCLIENT-1:0]  win;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      areq_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      areq_q  <= areq_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|c_areq)    state_d = ST_REQ;
      ST_REQ:  if (fdma_busy)  state_d = ST_BUSY;
      ST_BUSY: if (!fdma_busy) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Requests are only sampled in IDLE; address/size are frozen until the burst retires.
  always_comb begin
    win    = rr_pick(c_areq, last_q);
    gnt_d  = gnt_q;
    last_d = last_q;
    areq_d = areq_q;
    addr_d = addr_q;
    size_d = size_q;
    case (state_q)
      ST_IDLE: begin
        if (|c_areq) begin
          gnt_d  = win;
          areq_d = 1'b1;
          addr_d = win[1] ? c_addr[1] : c_addr[0];
          size_d = win[1] ? c_size[1] : c_size[0];
        end
      end
      ST_REQ: begin
        if (fdma_busy) areq_d = 1'b0;
      end
      ST_BUSY: begin
        if (!fdma_busy) begin
          gnt_d  = '0;
          last_d = gnt_q[1];
        end
      end
      default: begin
        gnt_d  = '0;
        areq_d = 1'b0;
      end
    endcase
  end

  // Grant is all-zero in IDLE, so the mux naturally idles at zero.
  always_comb begin
    fdma_data  = '0;
    fdma_ready = 1'b0;
    c_valid    = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (gnt_q[i]) begin
        fdma_data  = c_data[i];
        fdma_ready = c_ready[i];
        c_valid[i] = fdma_valid;
      end
    end
  end

  assign c_busy    = gnt_q;
  assign gnt       = gnt_q;
  assign fdma_areq = areq_q;
  assign fdma_addr = addr_q;
  assign fdma_size = size_q;

endmodule

// File: rtl/fdma_arb2.sv
// rtl/fdma_arb2.sv - two-client FDMA arbiter, independent write and read channels
module fdma_arb2
  import fdma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              ui_clk,
  input  logic              fdma_rstn,
  input  logic [ADDR_W-1:0] c0_waddr,
  input  logic              c0_wareq,
  input  logic [SIZE_W-1:0] c0_wsize,
  output logic              c0_wbusy,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_wvalid,
  input  logic              c0_wready,
  input  logic [ADDR_W-1:0] c0_raddr,
  input  logic              c0_rareq,
  input  logic [SIZE_W-1:0] c0_rsize,
  output logic              c0_rbusy,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_rvalid,
  input  logic              c0_rready,
  input  logic [ADDR_W-1:0] c1_waddr,
  input  logic              c1_wareq,
  input  logic [SIZE_W-1:0] c1_wsize,
  output logic              c1_wbusy,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_wvalid,
  input  logic              c1_wready,
  input  logic [ADDR_W-1:0] c1_raddr,
  input  logic              c1_rareq,
  input  logic [SIZE_W-1:0] c1_rsize,
  output logic              c1_rbusy,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_rvalid,
  input  logic              c1_rready,
  output logic [ADDR_W-1:0] fdma_waddr,
  output logic              fdma_wareq,
  output logic [SIZE_W-1:0] fdma_wsize,
  input  logic              fdma_wbusy,
  output logic [DATA_W-1:0] fdma_wdata,
  input  logic              fdma_wvalid,
  output logic              fdma_wready,
  output logic [ADDR_W-1:0] fdma_raddr,
  output logic              fdma_rareq,
  output logic [SIZE_W-1:0] fdma_rsize,
  input  logic              fdma_rbusy,
  input  logic [DATA_W-1:0] fdma_rdata,
  input  logic              fdma_rvalid,
  output logic              fdma_rready,
  output logic [1:0]        wgnt,
  output logic [1:0]        rgnt
);

  logic [NCLIENT-1:0] w_busy, w_valid, r_busy, r_valid;
  logic [DATA_W-1:0]  rd_mux_unused;

  fdma_arb_ch #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)) u_wr_ch (
    .clk        (ui_clk),
    .rstn       (fdma_rstn),
    .c_areq     ({c1_wareq, c0_wareq}),
    .c_addr     ({c1_waddr, c0_waddr}),
    .c_size     ({c1_wsize, c0_wsize}),
    .c_data     ({c1_wdata, c0_wdata}),
    .c_ready    ({c1_wready, c0_wready}),
    .c_busy     (w_busy),
    .c_valid    (w_valid),
    .fdma_addr  (fdma_waddr),
    .fdma_size  (fdma_wsize),
    .fdma_areq  (fdma_wareq),
    .fdma_busy  (fdma_wbusy),
    .fdma_valid (fdma_wvalid),
    .fdma_data  (fdma_wdata),
    .fdma_ready (fdma_wready),
    .gnt        (wgnt)
  );

  // Read data flows core-to-client, so this instance's client data mux carries nothing.
  fdma_arb_ch #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)) u_rd_ch (
    .clk        (ui_clk),
    .rstn       (fdma_rstn),
    .c_areq     ({c1_rareq, c0_rareq}),
    .c_addr     ({c1_raddr, c0_raddr}),
    .c_size     ({c1_rsize, c0_rsize}),
    .c_data     ('0),
    .c_ready    ({c1_rready, c0_rready}),
    .c_busy     (r_busy),
    .c_valid    (r_valid),
    .fdma_addr  (fdma_raddr),
    .fdma_size  (fdma_rsize),
    .fdma_areq  (fdma_rareq),
    .fdma_busy  (fdma_rbusy),
    .fdma_valid (fdma_rvalid),
    .fdma_data  (rd_mux_unused),
    .fdma_ready (fdma_rready),
    .gnt        (rgnt)
  );

  assign c0_wbusy  = w_busy[0];
  assign c1_wbusy  = w_busy[1];
  assign c0_wvalid = w_valid[0];
  assign c1_wvalid = w_valid[1];
  assign c0_rbusy  = r_busy[0];
  assign c1_rbusy  = r_busy[1];
  assign c0_rvalid = r_valid[0];
  assign c1_rvalid = r_valid[1];
  assign c0_rdata  = fdma_rdata;
  assign c1_rdata  = fdma_rdata;

endmodule

// File: tb/tb_fdma_arb2.sv
// tb/tb_fdma_arb2.sv - directed self-checking bench for fdma_arb2 with a small FDMA core model
module tb_fdma_arb2;

  localparam int AW = 32, SW = 16, DW = 128;
  localparam int W_LAT = 3, R_LAT = 2;

  logic          ui_clk = 1'b0;
  logic          fdma_rstn = 1'b0;
  logic [AW-1:0] c0_waddr = '0, c1_waddr = '0, c0_raddr = '0, c1_raddr = '0;
  logic          c0_wareq = 1'b0, c1_wareq = 1'b0, c0_rareq = 1'b0, c1_rareq = 1'b0;
  logic [SW-1:0] c0_wsize = '0, c1_wsize = '0, c0_rsize = '0, c1_rsize = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic          c0_wready = 1'b0, c1_wready = 1'b0, c0_rready = 1'b0, c1_rready = 1'b0;
  logic          c0_wbusy, c1_wbusy, c0_wvalid, c1_wvalid;
  logic          c0_rbusy, c1_rbusy, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [AW-1:0] fdma_waddr, fdma_raddr;
  logic          fdma_wareq, fdma_rareq, fdma_wready, fdma_rready;
  logic [SW-1:0] fdma_wsize, fdma_rsize;
  logic [DW-1:0] fdma_wdata;
  logic          fdma_wbusy = 1'b0, fdma_wvalid = 1'b0, fdma_rbusy = 1'b0, fdma_rvalid = 1'b0;
  logic [DW-1:0] fdma_rdata = '0;
  logic [1:0]    wgnt, rgnt;

  int checks = 0;
  int errors = 0;
  int w_ph = 0, w_cnt = 0, w_len = 0;
  int r_ph = 0, r_cnt = 0, r_len = 0;

  fdma_arb2 dut (
    .ui_clk(ui_clk), .fdma_rstn(fdma_rstn),
    .c0_waddr(c0_waddr), .c0_wareq(c0_wareq), .c0_wsize(c0_wsize), .c0_wbusy(c0_wbusy),
    .c0_wdata(c0_wdata), .c0_wvalid(c0_wvalid), .c0_wready(c0_wready),
    .c0_raddr(c0_raddr), .c0_rareq(c0_rareq), .c0_rsize(c0_rsize), .c0_rbusy(c0_rbusy),
    .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid), .c0_rready(c0_rready),
    .c1_waddr(c1_waddr), .c1_wareq(c1_wareq), .c1_wsize(c1_wsize), .c1_wbusy(c1_wbusy),
    .c1_wdata(c1_wdata), .c1_wvalid(c1_wvalid), .c1_wready(c1_wready),
    .c1_raddr(c1_raddr), .c1_rareq(c1_rareq), .c1_rsize(c1_rsize), .c1_rbusy(c1_rbusy),
    .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid), .c1_rready(c1_rready),
    .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize),
    .fdma_wbusy(fdma_wbusy), .fdma_wdata(fdma_wdata), .fdma_wvalid(fdma_wvalid),
    .fdma_wready(fdma_wready),
    .fdma_raddr(fdma_raddr), .fdma_rareq(fdma_rareq), .fdma_rsize(fdma_rsize),
    .fdma_rbusy(fdma_rbusy), .fdma_rdata(fdma_rdata), .fdma_rvalid(fdma_rvalid),
    .fdma_rready(fdma_rready),
    .wgnt(wgnt), .rgnt(rgnt)
  );

  always #5 ui_clk = ~ui_clk;

  // FDMA core model: busy W_LAT/R_LAT cycles after areq, then fdma_xsize strobes, then busy drops.
  always @(posedge ui_clk) begin
    #1;
    if (!fdma_rstn) begin
      w_ph = 0; fdma_wbusy = 1'b0; fdma_wvalid = 1'b0;
      r_ph = 0; fdma_rbusy = 1'b0; fdma_rvalid = 1'b0;
    end else begin
      case (w_ph)
        0: if (fdma_wareq) begin w_cnt = 1; w_len = int'(fdma_wsize); w_ph = 1; end
        1: if (w_cnt == W_LAT) begin fdma_wbusy = 1'b1; w_cnt = 0; w_ph = 2; end else w_cnt++;
        default:
          if (w_cnt < w_len) begin fdma_wvalid = 1'b1; w_cnt++; end
          else begin fdma_wvalid = 1'b0; fdma_wbusy = 1'b0; w_ph = 0; end
      endcase
      case (r_ph)
        0: if (fdma_rareq) begin r_cnt = 1; r_len = int'(fdma_rsize); r_ph = 1; end
        1: if (r_cnt == R_LAT) begin fdma_rbusy = 1'b1; r_cnt = 0; r_ph = 2; end else r_cnt++;
        default:
          if (r_cnt < r_len) begin
            fdma_rvalid = 1'b1; fdma_rdata = DW'(r_cnt) + 128'hA5A5_0000; r_cnt++;
          end else begin fdma_rvalid = 1'b0; fdma_rbusy = 1'b0; r_ph = 0; end
      endcase
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge ui_clk);
      if (wgnt == 2'b00 && rgnt == 2'b00 && !fdma_wbusy && !fdma_rbusy && w_ph == 0 && r_ph == 0)
        ok = 1'b1;
    end
    @(negedge ui_clk);
  endtask

  task automatic test_reset();
    fdma_rstn = 1'b0;
    c0_wdata  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    c0_wready = 1'b1;
    repeat (2) @(negedge ui_clk);
    checks++; if (wgnt !== 2'b00) begin errors++; $display("FAIL reset_wgnt: got %b expected 00", wgnt); end
    checks++; if (rgnt !== 2'b00) begin errors++; $display("FAIL reset_rgnt: got %b expected 00", rgnt); end
    checks++; if (fdma_wareq !== 1'b0 || fdma_rareq !== 1'b0) begin errors++; $display("FAIL reset_areq: got %b%b expected 00", fdma_wareq, fdma_rareq); end
    checks++; if (c0_wbusy !== 1'b0 || c1_rbusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", c0_wbusy, c1_rbusy); end
    checks++; if (fdma_waddr !== 32'h0 || fdma_wsize !== 16'h0) begin errors++; $display("FAIL reset_latch: got %h/%h expected 0/0", fdma_waddr, fdma_wsize); end
    checks++; if (fdma_wready !== 1'b0 || fdma_wdata !== 128'h0) begin errors++; $display("FAIL reset_wmux: got %b/%h expected 0/0", fdma_wready, fdma_wdata); end
    fdma_rstn = 1'b1;
    @(negedge ui_clk);
  endtask

  task automatic test_single_write();
    int n0 = 0, n1 = 0;
    bit done = 1'b0, prev = 1'b0;
    c0_waddr = 32'h0320_0000; c0_wsize = 16'd1000; c0_wready = 1'b1;
    c0_wdata = 128'hDEAD_BEEF_0000_0001_0000_0002_CAFE_F00D;
    c0_wareq = 1'b1;
    @(negedge ui_clk);
    checks++; if (fdma_wareq !== 1'b1 || c0_wbusy !== 1'b1) begin errors++; $display("FAIL single_grant_latency: got areq=%b busy=%b expected 1/1", fdma_wareq, c0_wbusy); end
    checks++; if (fdma_waddr !== 32'h0320_0000) begin errors++; $display("FAIL single_waddr: got %h expected 03200000", fdma_waddr); end
    checks++; if (fdma_wsize !== 16'd1000) begin errors++; $display("FAIL single_wsize: got %0d expected 1000", fdma_wsize); end
    checks++; if (wgnt !== 2'b01 || c1_wbusy !== 1'b0) begin errors++; $display("FAIL single_wgnt: got %b c1busy=%b expected 01/0", wgnt, c1_wbusy); end
    checks++; if (fdma_wdata !== c0_wdata || fdma_wready !== 1'b1) begin errors++; $display("FAIL single_wmux: got %h/%b expected %h/1", fdma_wdata, fdma_wready, c0_wdata); end
    c0_wareq = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge ui_clk);
      if (c0_wvalid) n0++;
      if (c1_wvalid) n1++;
      if (prev && !fdma_wbusy) begin
        checks++; if (c0_wbusy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b expected 1", c0_wbusy); end
        @(negedge ui_clk);
        checks++; if (c0_wbusy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", c0_wbusy); end
        done = 1'b1;
      end
      prev = fdma_wbusy;
    end
    checks++; if (!done) begin errors++; $display("FAIL single_timeout: got no burst end expected end within 3000 cycles"); end
    checks++; if (n0 != 1000) begin errors++; $display("FAIL single_c0_beats: got %0d expected 1000", n0); end
    checks++; if (n1 != 0) begin errors++; $display("FAIL single_c1_beats: got %0d expected 0", n1); end
  endtask

  task automatic test_tie();
    bit done = 1'b0, prev = 1'b0, ok;
    fdma_rstn = 1'b0;
    repeat (2) @(negedge ui_clk);
    fdma_rstn = 1'b1;
    c0_waddr = 32'h0000_1000; c0_wsize = 16'd4;
    c1_waddr = 32'h0000_2000; c1_wsize = 16'd6;
    c0_wareq = 1'b1; c1_wareq = 1'b1;
    @(negedge ui_clk);
    checks++; if (wgnt !== 2'b01) begin errors++; $display("FAIL tie_first: got %b expected 01", wgnt); end
    c0_wareq = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ui_clk);
      if (prev && !fdma_wbusy) done = 1'b1;
      prev = fdma_wbusy;
    end
    checks++; if (!done) begin errors++; $display("FAIL tie_timeout: got no burst end expected end within 200 cycles"); end
    @(negedge ui_clk);
    checks++; if (wgnt !== 2'b00) begin errors++; $display("FAIL tie_gap: got %b expected 00", wgnt); end
    @(negedge ui_clk);
    checks++; if (wgnt !== 2'b10 || c1_wbusy !== 1'b1) begin errors++; $display("FAIL tie_second: got %b busy=%b expected 10/1", wgnt, c1_wbusy); end
    checks++; if (fdma_waddr !== 32'h0000_2000 || fdma_wsize !== 16'd6) begin errors++; $display("FAIL tie_latch: got %h/%0d expected 00002000/6", fdma_waddr, fdma_wsize); end
    c1_wareq = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_idle: got busy expected idle"); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    logic [1:0] prev = 2'b00, exp;
    bit ok;
    c0_wsize = 16'd8; c1_wsize = 16'd8;
    c0_wareq = 1'b1; c1_wareq = 1'b1;
    for (int i = 0; i < 400 && k < 4; i++) begin
      @(negedge ui_clk);
      if (wgnt != 2'b00 && prev == 2'b00) begin
        exp = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (wgnt !== exp) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", k, wgnt, exp); end
        k++;
        if (k == 4) begin c0_wareq = 1'b0; c1_wareq = 1'b0; end
      end
      prev = wgnt;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL b2b_count: got %0d grants expected 4", k); end
    c0_wareq = 1'b0; c1_wareq = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_concurrent();
    int nw = 0, nr1 = 0, nr0 = 0;
    bit wd = 1'b0, rd = 1'b0, pw = 1'b0, pr = 1'b0, bcast_ok = 1'b1, ok;
    c0_waddr = 32'h0400_0000; c0_wsize = 16'd16; c0_wready = 1'b1;
    c1_raddr = 32'h0800_0000; c1_rsize = 16'd16; c1_rready = 1'b1; c0_rready = 1'b0;
    c0_wareq = 1'b1; c1_rareq = 1'b1;
    @(negedge ui_clk);
    checks++; if (wgnt !== 2'b01 || rgnt !== 2'b10) begin errors++; $display("FAIL conc_grants: got w=%b r=%b expected 01/10", wgnt, rgnt); end
    checks++; if (fdma_raddr !== 32'h0800_0000 || fdma_rready !== 1'b1) begin errors++; $display("FAIL conc_rlatch: got %h/%b expected 08000000/1", fdma_raddr, fdma_rready); end
    c0_wareq = 1'b0; c1_rareq = 1'b0;
    for (int i = 0; i < 300 && !(wd && rd); i++) begin
      @(negedge ui_clk);
      if (c0_wvalid) nw++;
      if (c1_rvalid) nr1++;
      if (c0_rvalid) nr0++;
      if (fdma_rvalid && (c0_rdata !== fdma_rdata || c1_rdata !== fdma_rdata)) bcast_ok = 1'b0;
      if (pw && !fdma_wbusy) wd = 1'b1;
      if (pr && !fdma_rbusy) rd = 1'b1;
      pw = fdma_wbusy; pr = fdma_rbusy;
    end
    checks++; if (!(wd && rd)) begin errors++; $display("FAIL conc_timeout: got w=%b r=%b expected both done", wd, rd); end
    checks++; if (nr1 != 16) begin errors++; $display("FAIL conc_c1_rvalid: got %0d expected 16", nr1); end
    checks++; if (nr0 != 0) begin errors++; $display("FAIL conc_c0_rvalid: got %0d expected 0", nr0); end
    checks++; if (nw != 16) begin errors++; $display("FAIL conc_c0_wvalid: got %0d expected 16", nw); end
    checks++; if (!bcast_ok) begin errors++; $display("FAIL conc_rdata_bcast: got mismatch expected broadcast"); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_burst();
    int n0 = 0;
    bit ok;
    c0_waddr = 32'h0500_0000; c0_wsize = 16'd1000; c0_wready = 1'b1;
    c0_wareq = 1'b1;
    @(negedge ui_clk);
    c0_wareq = 1'b0;
    for (int i = 0; i < 1000 && n0 < 500; i++) begin
      @(negedge ui_clk);
      if (c0_wvalid) n0++;
    end
    checks++; if (n0 != 500) begin errors++; $display("FAIL rst_mid_beats: got %0d expected 500", n0); end
    fdma_rstn = 1'b0;
    c1_waddr = 32'h0600_0000; c1_wsize = 16'd4;
    @(negedge ui_clk);
    checks++; if (wgnt !== 2'b00 || c0_wbusy !== 1'b0 || fdma_wareq !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got gnt=%b busy=%b areq=%b expected 00/0/0", wgnt, c0_wbusy, fdma_wareq); end
    checks++; if (fdma_waddr !== 32'h0 || fdma_wsize !== 16'h0 || c0_wvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_data: got %h/%0d/%b expected 0/0/0", fdma_waddr, fdma_wsize, c0_wvalid); end
    fdma_rstn = 1'b1;
    c1_wareq = 1'b1;
    @(negedge ui_clk);
    checks++; if (wgnt !== 2'b10 || c1_wbusy !== 1'b1 || fdma_waddr !== 32'h0600_0000) begin errors++; $display("FAIL rst_mid_regrant: got %b/%b/%h expected 10/1/06000000", wgnt, c1_wbusy, fdma_waddr); end
    c1_wareq = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_idle: got busy expected idle"); end
  endtask

  task automatic test_addr_hold();
    bit done = 1'b0, prev = 1'b0, held = 1'b1, ok;
    logic [AW-1:0] bad = '0;
    c0_waddr = 32'h1000_0000; c0_wsize = 16'd32;
    c0_wareq = 1'b1;
    @(negedge ui_clk);
    c0_waddr = 32'hFFFF_0000;
    c0_wareq = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ui_clk);
      if (fdma_waddr !== 32'h1000_0000 && held) begin held = 1'b0; bad = fdma_waddr; end
      if (prev && !fdma_wbusy) done = 1'b1;
      prev = fdma_wbusy;
    end
    checks++; if (!done) begin errors++; $display("FAIL hold_timeout: got no burst end expected end within 200 cycles"); end
    checks++; if (!held) begin errors++; $display("FAIL hold_waddr: got %h expected 10000000", bad); end
    checks++; if (fdma_wsize !== 16'd32) begin errors++; $display("FAIL hold_wsize: got %0d expected 32", fdma_wsize); end
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_concurrent();
    test_reset_mid_burst();
    test_addr_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
